// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART transmit path
package uart_pkg;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_FRAME_BITS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } uart_arb_state_t;

    function automatic int frame_cycles(input int clkdiv, input int frame_bits);
        return clkdiv * frame_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with a rotating priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic                 advance,
    output logic [N-1:0]         grant_onehot,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int              IW   = $clog2(N);
    localparam logic [IW:0]     N_W  = (IW+1)'(N);
    localparam logic [IW-1:0]   LAST = IW'(N-1);

    // r_ptr is the index holding highest priority, i.e. last grant + 1
    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_k;
    logic          w_found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        w_found      = 1'b0;
        w_k          = '0;
        for (int i = 0; i < N; i++) begin
            w_k = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_k >= N_W) begin
                w_k = w_k - N_W;
            end
            if (en && !w_found && req[w_k[IW-1:0]]) begin
                w_found   = 1'b1;
                grant_idx = w_k[IW-1:0];
            end
        end
        if (w_found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one uart_tx among NREQ byte producers
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int CLKDIV     = 32,
    parameter int FRAME_BITS = UART_FRAME_BITS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [UART_DATA_BITS*NREQ-1:0] req_data,
    output logic [NREQ-1:0]                req_ready,
    output logic [UART_DATA_BITS-1:0]      tx_data,
    output logic                           tx_send,
    output logic                           busy,
    output logic [$clog2(NREQ)-1:0]        grant_id
);

    localparam int            FC        = frame_cycles(CLKDIV, FRAME_BITS);
    localparam int            CW        = $clog2(FC);
    localparam int            IW        = $clog2(NREQ);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(FC - 2);

    uart_arb_state_t             r_state;
    uart_arb_state_t             w_next_state;
    logic [CW-1:0]               r_count;
    logic [UART_DATA_BITS-1:0]   r_tx_data;
    logic                        r_tx_send;
    logic [IW-1:0]               r_grant_id;
    logic [NREQ-1:0]             w_grant_onehot;
    logic [IW-1:0]               w_grant_idx;
    logic                        w_arb_en;
    logic                        w_handshake;

    // Gating with rst_n keeps req_ready low while reset is held
    assign w_arb_en    = (r_state == IDLE) && rst_n;
    assign w_handshake = |(req_valid & w_grant_onehot);

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_valid),
        .en           (w_arb_en),
        .advance      (w_handshake),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_handshake) w_next_state = SEND;
            SEND:    w_next_state = WAIT;
            WAIT:    if (r_count == '0) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // SEND plus the WAIT countdown spans exactly one frame on the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_tx_data  <= '0;
            r_tx_send  <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_tx_send <= w_handshake;
            if (w_handshake) begin
                r_tx_data  <= req_data[w_grant_idx*UART_DATA_BITS +: UART_DATA_BITS];
                r_grant_id <= w_grant_idx;
            end
            if (r_state == SEND) begin
                r_count <= WAIT_LOAD;
            end else if (r_state == WAIT && r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign req_ready = w_grant_onehot;
    assign tx_data   = r_tx_data;
    assign tx_send   = r_tx_send;
    assign busy      = (r_state != IDLE);
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        busy;
    logic [1:0]  grant_id;

    logic        rst_n_b = 1'b1;
    logic [1:0]  req_valid_b = 2'b01;
    logic [15:0] req_data_b = 16'h005A;
    logic [1:0]  req_ready_b;
    logic [7:0]  tx_data_b;
    logic        tx_send_b;
    logic        busy_b;
    logic        grant_id_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NREQ(4), .CLKDIV(32), .FRAME_BITS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    uart_tx_arbiter #(.NREQ(2), .CLKDIV(4), .FRAME_BITS(11)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .req_valid (req_valid_b),
        .req_data  (req_data_b),
        .req_ready (req_ready_b),
        .tx_data   (tx_data_b),
        .tx_send   (tx_send_b),
        .busy      (busy_b),
        .grant_id  (grant_id_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the cycle in which req_ready is nonzero
    task automatic wait_ready(input string tag, output int stamp);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == 4'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == 4'b0) check({tag, " ready timeout"}, 32'd0, 32'd1);
        stamp = cyc;
    endtask

    task automatic accept(input int idx);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic drain(input string tag, output int pulses, output int idle_stamp);
        int n;
        n = 0;
        pulses = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            if (tx_send) pulses++;
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, " drain timeout"}, 32'd0, 32'd1);
        idle_stamp = cyc;
        @(posedge clk);
        #1;
    endtask

    int t_hs, t_prev, t_idle, pulses, n_sends, n_busy, n_rdy;
    int stamps[4];

    initial begin
        #2;
        rst_n     = 1'b0;
        rst_n_b   = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        check("reset tx_send", {31'd0, tx_send}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset grant_id", {30'd0, grant_id}, 32'd0);
        check("reset tx_data", {24'd0, tx_data}, 32'd0);
        check("reset req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rst_n_b = 1'b1;

        // single requester 1 with 0x55
        @(posedge clk);
        #1;
        req_valid[1]    = 1'b1;
        req_data[15:8]  = 8'h55;
        wait_ready("single", t_hs);
        check("single req_ready", {28'd0, req_ready}, 32'h2);
        accept(1);
        @(negedge clk);
        check("single tx_send", {31'd0, tx_send}, 32'd1);
        check("single tx_data", {24'd0, tx_data}, 32'h55);
        check("single grant_id", {30'd0, grant_id}, 32'd1);
        check("single busy", {31'd0, busy}, 32'd1);
        check("single ready in SEND", {28'd0, req_ready}, 32'd0);
        drain("single", pulses, t_idle);
        check("single extra pulses", pulses, 32'd0);
        check("single busy low cycle", t_idle - t_hs, 32'd321);

        // grant 2, then 0 and 3 together: 3 must win
        req_valid[2]    = 1'b1;
        req_data[23:16] = 8'h22;
        wait_ready("fair2", t_hs);
        check("fair grant2 ready", {28'd0, req_ready}, 32'h4);
        accept(2);
        drain("fair2", pulses, t_idle);
        req_valid[0]    = 1'b1;
        req_valid[3]    = 1'b1;
        req_data[7:0]   = 8'h0A;
        req_data[31:24] = 8'h3A;
        wait_ready("fair3", t_hs);
        check("fair 3 before 0", {28'd0, req_ready}, 32'h8);
        accept(3);
        @(negedge clk);
        check("fair grant_id 3", {30'd0, grant_id}, 32'd3);
        check("fair tx_data 3", {24'd0, tx_data}, 32'h3A);
        t_prev = t_hs;
        wait_ready("fair0", t_hs);
        check("fair 0 ready", {28'd0, req_ready}, 32'h1);
        check("fair spacing", t_hs - t_prev, 32'd321);
        accept(0);
        drain("fair0", pulses, t_idle);

        // all four valid from reset
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hA3A2A1A0;
        @(negedge clk);
        check("rst gates ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready("all", t_hs);
            check($sformatf("all ready %0d", k), {28'd0, req_ready}, 32'd1 << k);
            if (k > 0) check($sformatf("all spacing %0d", k), t_hs - t_prev, 32'd321);
            t_prev = t_hs;
            accept(k);
            @(negedge clk);
            check($sformatf("all tx_send %0d", k), {31'd0, tx_send}, 32'd1);
            check($sformatf("all tx_data %0d", k), {24'd0, tx_data}, 32'hA0 + k);
            check($sformatf("all grant_id %0d", k), {30'd0, grant_id}, k);
        end
        drain("all", pulses, t_idle);

        // withdrawn request: 2 pulses valid during WAIT only
        req_valid[1]   = 1'b1;
        req_data[15:8] = 8'h11;
        wait_ready("wd", t_hs);
        accept(1);
        repeat (50) @(posedge clk);
        #1;
        req_valid[2]    = 1'b1;
        req_data[23:16] = 8'h77;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("wd ready in WAIT", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        drain("wd", pulses, t_idle);
        check("wd pulses in WAIT", pulses, 32'd0);
        n_sends = 0;
        n_busy  = 0;
        n_rdy   = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx_send) n_sends++;
            if (busy) n_busy++;
            if (req_ready != 4'b0) n_rdy++;
        end
        check("wd no send", n_sends, 32'd0);
        check("wd busy stays low", n_busy, 32'd0);
        check("wd no ready", n_rdy, 32'd0);

        // reset mid-frame; pointer sits at 2 after granting 1
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        wait_ready("mid", t_hs);
        check("mid ready 1", {28'd0, req_ready}, 32'h2);
        accept(1);
        req_valid[0]    = 1'b1;
        req_valid[3]    = 1'b1;
        req_data[7:0]   = 8'h0F;
        req_data[31:24] = 8'h3C;
        repeat (101) @(posedge clk);
        #1;
        check("mid busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst tx_send", {31'd0, tx_send}, 32'd0);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst grant_id", {30'd0, grant_id}, 32'd0);
        check("mid rst tx_data", {24'd0, tx_data}, 32'd0);
        check("mid rst ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("mid rel", t_hs);
        check("mid rel ready 0", {28'd0, req_ready}, 32'h1);
        accept(0);
        @(negedge clk);
        check("mid rel grant_id", {30'd0, grant_id}, 32'd0);
        check("mid rel tx_data", {24'd0, tx_data}, 32'h0F);
        req_valid[3] = 1'b0;
        drain("mid", pulses, t_idle);

        // CLKDIV=4, FRAME_BITS=11 instance, requester 0 always valid
        n_sends = 0;
        for (int n = 0; n < 400 && n_sends < 4; n++) begin
            @(negedge clk);
            if (tx_send_b) begin
                stamps[n_sends] = cyc;
                n_sends++;
            end
        end
        check("sweep send count", n_sends, 32'd4);
        for (int k = 1; k < 4; k++) begin
            if (k < n_sends) check($sformatf("sweep spacing %0d", k), stamps[k] - stamps[k-1], 32'd45);
        end
        check("sweep tx_data", {24'd0, tx_data_b}, 32'h5A);
        check("sweep grant_id", {31'd0, grant_id_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
